// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   size_e  - RV64 funct3 access-size codes (signed and unsigned loads)
//   state_e - load/store FSM states
//   Be*     - byte-enable base patterns before shifting by the address offset
package lsu_pkg;

    typedef enum logic [2:0] {
        SizeB  = 3'b000,
        SizeH  = 3'b001,
        SizeW  = 3'b010,
        SizeD  = 3'b011,
        SizeBu = 3'b100,
        SizeHu = 3'b101,
        SizeWu = 3'b110
    } size_e;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_e;

    localparam logic [7:0] BeByte   = 8'h01;
    localparam logic [7:0] BeHalf   = 8'h03;
    localparam logic [7:0] BeWord   = 8'h0F;
    localparam logic [7:0] BeDouble = 8'hFF;

    // funct3[1:0] encodes log2 of the access size for every legal code.
    function automatic logic [7:0] be_base(input logic [1:0] size_log2);
        logic [7:0] be;
        case (size_log2)
            2'b00:   be = BeByte;
            2'b01:   be = BeHalf;
            2'b10:   be = BeWord;
            default: be = BeDouble;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load-data extraction.
// Shifts the read doubleword down by the byte offset, then sign- or
// zero-extends the selected field to 64 bits according to funct3.
//   rdata  in  64  read doubleword from memory
//   offset in  3   byte offset within the doubleword (addr[2:0])
//   funct3 in  3   access size code
//   result out 64  aligned, extended load value (0 for an unused code)
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] result
);

    logic [63:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        result = '0;
        case (funct3)
            SizeB:   result = {{56{shifted[7]}}, shifted[7:0]};
            SizeH:   result = {{48{shifted[15]}}, shifted[15:0]};
            SizeW:   result = {{32{shifted[31]}}, shifted[31:0]};
            SizeD:   result = shifted;
            SizeBu:  result = {56'd0, shifted[7:0]};
            SizeHu:  result = {48'd0, shifted[15:0]};
            SizeWu:  result = {32'd0, shifted[31:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV64 load/store unit with a three-state FSM (IDLE, REQ, DONE).
// Accepts one request at a time, checks it for illegal/misaligned faults,
// places store data on byte lanes, issues a single doubleword memory access
// and returns the aligned, extended load result with a one-cycle o_done.
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_req_valid / o_req_ready    request handshake (ready only in IDLE)
//   i_is_store, i_funct3         direction and size code
//   i_addr, i_store_data         effective address and rs2 value
//   o_done, o_load_data          completion pulse and load result
//   o_misaligned, o_illegal      fault flags, valid with o_done
//   o_mem_req/we/addr/wdata/be   memory request, held stable during REQ
//   i_mem_ack, i_mem_rdata       memory completion and read doubleword
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_is_store,
    input  logic [2:0]            i_funct3,
    input  logic [DATA_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_store_data,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_load_data,
    output logic                  o_misaligned,
    output logic                  o_illegal,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_addr,
    output logic [63:0]           o_mem_wdata,
    output logic [7:0]            o_mem_be,
    input  logic                  i_mem_ack,
    input  logic [63:0]           i_mem_rdata
);

    state_e                state_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic                  done_q;
    logic                  misaligned_q;
    logic                  illegal_q;
    logic                  is_store_q;
    logic [2:0]            funct3_q;
    logic [2:0]            offset_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [63:0]           wdata_q;
    logic [7:0]            be_q;
    logic [63:0]           load_data_q;

    // Request decode, evaluated on the incoming request.
    logic [2:0]  req_offset;
    logic [1:0]  req_size;
    logic        req_illegal;
    logic        req_misaligned_raw;
    logic        req_misaligned;
    logic        req_fault;
    logic [63:0] store_data64;
    logic [63:0] wdata_next;
    logic [7:0]  be_next;
    logic [63:0] load_ext;

    assign req_offset   = i_addr[2:0];
    assign req_size     = i_funct3[1:0];
    assign store_data64 = 64'(i_store_data);

    // Stores have no unsigned variants; loads reject only the unused code 111.
    assign req_illegal = i_is_store ? i_funct3[2] : (i_funct3 == 3'b111);

    always_comb begin
        req_misaligned_raw = 1'b0;
        case (req_size)
            2'b00:   req_misaligned_raw = 1'b0;
            2'b01:   req_misaligned_raw = req_offset[0];
            2'b10:   req_misaligned_raw = |req_offset[1:0];
            default: req_misaligned_raw = |req_offset;
        endcase
    end

    // Illegal wins so exactly one fault flag is ever set.
    assign req_misaligned = req_misaligned_raw & ~req_illegal;
    assign req_fault      = req_illegal | req_misaligned_raw;

    // Replicate the low field across all lanes; be selects the live lanes.
    always_comb begin
        wdata_next = '0;
        case (req_size)
            2'b00:   wdata_next = {8{store_data64[7:0]}};
            2'b01:   wdata_next = {4{store_data64[15:0]}};
            2'b10:   wdata_next = {2{store_data64[31:0]}};
            default: wdata_next = store_data64;
        endcase
    end

    assign be_next = be_base(req_size) << req_offset;

    lsu_load_align u_load_align (
        .rdata  (i_mem_rdata),
        .offset (offset_q),
        .funct3 (funct3_q),
        .result (load_ext)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            offset_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            load_data_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_req_valid) begin
                        is_store_q   <= i_is_store;
                        funct3_q     <= i_funct3;
                        offset_q     <= req_offset;
                        addr_q       <= {i_addr[DATA_WIDTH-1:3], 3'b000};
                        misaligned_q <= req_misaligned;
                        illegal_q    <= req_illegal;
                        load_data_q  <= '0;
                        if (req_fault) begin
                            // Faults complete without touching memory.
                            state_q   <= StDone;
                            done_q    <= 1'b1;
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                            wdata_q   <= '0;
                            be_q      <= '0;
                        end else begin
                            state_q   <= StReq;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= i_is_store;
                            wdata_q   <= wdata_next;
                            be_q      <= be_next;
                        end
                    end
                end
                StReq: begin
                    if (i_mem_ack) begin
                        state_q   <= StDone;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        done_q    <= 1'b1;
                        if (!is_store_q) begin
                            load_data_q <= load_ext;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q   <= StIdle;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are forced low during the first reset cycle too, before the
    // synchronous clear has had an edge to act on.
    assign o_req_ready  = (state_q == StIdle) & ~i_rst;
    assign o_done       = done_q & ~i_rst;
    assign o_misaligned = misaligned_q & ~i_rst;
    assign o_illegal    = illegal_q & ~i_rst;
    assign o_mem_req    = mem_req_q & ~i_rst;
    assign o_mem_we     = mem_we_q & ~i_rst;
    assign o_mem_addr   = i_rst ? '0 : addr_q;
    assign o_mem_wdata  = i_rst ? '0 : wdata_q;
    assign o_mem_be     = i_rst ? '0 : be_q;
    assign o_load_data  = i_rst ? '0 : DATA_WIDTH'(load_data_q);

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plus randomized checks of load_store_unit
// against a byte-level behavioural model of RV64 loads and stores.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] store_data;
    logic        done;
    logic [63:0] load_data;
    logic        misaligned;
    logic        illegal;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(64)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_is_store   (is_store),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_store_data (store_data),
        .o_done       (done),
        .o_load_data  (load_data),
        .o_misaligned (misaligned),
        .o_illegal    (illegal),
        .o_mem_req    (mem_req),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_be     (mem_be),
        .i_mem_ack    (mem_ack),
        .i_mem_rdata  (mem_rdata)
    );

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp)
        else begin
            nmis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        is_store   = 1'($urandom);
        funct3     = 3'($urandom);
        addr       = {$urandom, $urandom};
        store_data = {$urandom, $urandom};
    endtask

    // Reference model: bytes touched, lane contents and load value from the
    // access size in bytes and the offset, computed byte by byte.
    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] sd, input int delay, input logic [63:0] rd,
                           input logic stray);
        int          n;
        int          off;
        logic        ill;
        logic        mis;
        logic [7:0]  ebe;
        logic [63:0] ewd;
        logic [63:0] eld;

        n   = 1 << f3[1:0];
        off = int'(a[2:0]);
        ill = st ? (f3 >= 3'd4) : (f3 == 3'd7);
        mis = !ill && ((off % n) != 0);
        ebe = '0;
        ewd = '0;
        eld = '0;
        for (int i = 0; i < 8; i++) begin
            if (i >= off && i < off + n) ebe[i] = 1'b1;
            ewd[8*i +: 8] = sd[8*(i % n) +: 8];
        end
        if (!ill && !mis && !st) begin
            for (int i = 0; i < n; i++) eld[8*i +: 8] = rd[8*(off + i) +: 8];
            if ((f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) && eld[8*n-1]) begin
                for (int i = 8*n; i < 64; i++) eld[i] = 1'b1;
            end
        end

        chk1("ready_idle", req_ready, 1'b1);
        req_valid  = 1'b1;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        step();
        req_valid = stray;
        scramble_inputs();

        if (ill || mis) begin
            chk1("fault_done", done, 1'b1);
            chk1("fault_no_req", mem_req, 1'b0);
            chk1("fault_misaligned", misaligned, mis);
            chk1("fault_illegal", illegal, ill);
            chk64("fault_load_data", load_data, 64'd0);
            req_valid = 1'b0;
            step();
        end else begin
            for (int k = 0; k <= delay; k++) begin
                chk1("req_mem_req", mem_req, 1'b1);
                chk1("req_not_ready", req_ready, 1'b0);
                chk1("req_no_done", done, 1'b0);
                chk64("req_mem_addr", mem_addr, {a[63:3], 3'b000});
                chk1("req_mem_we", mem_we, st);
                chk64("req_mem_be", 64'(mem_be), 64'(ebe));
                if (st) chk64("req_mem_wdata", mem_wdata, ewd);
                if (k == delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                end else begin
                    mem_rdata = {$urandom, $urandom};
                end
                step();
                mem_ack   = 1'b0;
                mem_rdata = {$urandom, $urandom};
            end
            req_valid = 1'b0;
            chk1("done_pulse", done, 1'b1);
            chk1("done_mem_req_low", mem_req, 1'b0);
            chk1("done_misaligned", misaligned, 1'b0);
            chk1("done_illegal", illegal, 1'b0);
            chk64("done_load_data", load_data, eld);
            step();
        end
        chk1("done_one_cycle", done, 1'b0);
        chk1("ready_after_done", req_ready, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        is_store   = 1'b0;
        funct3     = '0;
        addr       = '0;
        store_data = '0;
        #1;
        chk1("rst_ready_low", req_ready, 1'b0);
        step();
        step();
        chk1("rst_ready", req_ready, 1'b0);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk64("rst_mem_be", 64'(mem_be), 64'd0);
        chk64("rst_mem_addr", mem_addr, 64'd0);
        chk64("rst_load_data", load_data, 64'd0);
        rst = 1'b0;
        #1;
        chk1("ready_after_rst", req_ready, 1'b1);

        // Sign vs zero extension of a word load from the upper half.
        run_txn(1'b0, 3'b010, 64'h1004, 64'd0, 1, 64'h87654321_00000000, 1'b0);
        run_txn(1'b0, 3'b110, 64'h1004, 64'd0, 0, 64'h87654321_00000000, 1'b0);
        // Byte store to the top byte of the low word.
        run_txn(1'b1, 3'b000, 64'h2003, 64'hAB, 0, 64'd0, 1'b0);
        // Faults: misaligned half, illegal load code, illegal store code.
        run_txn(1'b0, 3'b001, 64'h1001, 64'd0, 0, 64'd0, 1'b0);
        run_txn(1'b0, 3'b111, 64'h1000, 64'd0, 0, 64'd0, 1'b0);
        run_txn(1'b1, 3'b101, 64'h1003, 64'h55, 0, 64'd0, 1'b0);
        // Delayed ack with a second request held valid throughout.
        run_txn(1'b0, 3'b011, 64'h3008, 64'd0, 3, 64'hDEADBEEF_CAFEF00D, 1'b1);
        // Minimum-latency doubleword load.
        run_txn(1'b0, 3'b011, 64'h4010, 64'd0, 0, 64'h01234567_89ABCDEF, 1'b0);

        // Reset while in REQ abandons the access; a late ack is ignored.
        req_valid  = 1'b1;
        is_store   = 1'b0;
        funct3     = 3'b011;
        addr       = 64'h5000;
        step();
        req_valid = 1'b0;
        chk1("pre_rst_mem_req", mem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk1("rst_in_req_mem_req", mem_req, 1'b0);
        step();
        chk1("rst_in_req_done", done, 1'b0);
        chk64("rst_in_req_mem_be", 64'(mem_be), 64'd0);
        rst     = 1'b0;
        mem_ack = 1'b1;
        #1;
        chk1("ready_first_after_rst", req_ready, 1'b1);
        step();
        mem_ack = 1'b0;
        chk1("late_ack_no_done", done, 1'b0);
        chk1("late_ack_no_req", mem_req, 1'b0);
        chk1("late_ack_ready", req_ready, 1'b1);

        // Random traffic; low address bits biased toward aligned accesses.
        for (int t = 0; t < 200; t++) begin
            logic [63:0] ra;
            ra = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) ra[2:0] = ra[2:0] & ~((3'd1 << $urandom_range(0, 2)) - 3'd1);
            run_txn(1'($urandom), 3'($urandom), ra, {$urandom, $urandom},
                    int'($urandom_range(0, 3)), {$urandom, $urandom}, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the width of data and address paths.
REQ-002 i_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 i_rst  in  1  SHALL be the synchronous, active-high reset.
REQ-004 i_req_valid  in  1  SHALL mark a load/store request from the execute stage.
REQ-005 o_req_ready  out  1  SHALL be high only in IDLE and low while i_rst is high; a request is accepted when i_req_valid & o_req_ready.
REQ-006 i_is_store  in  1  SHALL select store (1) or load (0).
REQ-007 i_funct3  in  3  SHALL give the RV64 size code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-008 i_addr  in  DATA_WIDTH  SHALL be the effective byte address (ALU result).
REQ-009 i_store_data  in  DATA_WIDTH  SHALL be the rs2 store value, LSB-aligned.
REQ-010 o_done  out  1  SHALL pulse for one cycle when a request completes.
REQ-011 o_load_data  out  DATA_WIDTH  SHALL hold the aligned, extended load result; it is valid while o_done is high.
REQ-012 o_misaligned / o_illegal  out  1 each  SHALL flag the fault type and are valid while o_done is high.
REQ-013 o_mem_req, o_mem_we  out  1 each  SHALL carry the memory request and write enable.
REQ-014 o_mem_addr  out  DATA_WIDTH  SHALL be the doubleword-aligned address, i_addr with bits [2:0] forced to 0.
REQ-015 o_mem_wdata / o_mem_be  out  64 / 8  SHALL carry the lane-placed store data and the byte enables.
REQ-016 i_mem_ack / i_mem_rdata  in  1 / 64  SHALL carry the memory completion and the read doubleword.

Function
REQ-017 The FSM SHALL have the states IDLE, REQ and DONE.
REQ-018 Transitions SHALL be:
- IDLE->REQ on an accepted, legal, aligned request.
- IDLE->DONE on an accepted faulting request.
- REQ->DONE on i_mem_ack.
- DONE->IDLE unconditionally.
REQ-019 On acceptance, the block SHALL register the address, size, direction, store data and fault flags; inputs are don't-care afterwards.
REQ-020 o_mem_req SHALL be high exactly in REQ, with o_mem_addr, o_mem_we, o_mem_wdata and o_mem_be held stable until the ack.
REQ-021 An ack in the first REQ cycle SHALL be legal, giving the minimum latency: accept at T, req at T+1, o_done at T+2.
REQ-022 i_mem_ack SHALL be ignored outside REQ.
REQ-023 o_done SHALL be high exactly in DONE.
REQ-024 Misalignment SHALL be defined as: H/HU with addr[0]!=0; W/WU with addr[1:0]!=0; D with addr[2:0]!=0.
REQ-025 Illegal requests SHALL be: load funct3=111, and store funct3[2]=1.
REQ-026 A faulting request SHALL issue no memory request, SHALL set exactly one fault flag (illegal takes priority), and SHALL drive o_load_data=0.
REQ-027 Store lanes SHALL be set as follows:
- Byte enables: B 0x01, H 0x03, W 0x0F, D 0xFF, shifted left by addr[2:0].
- Data: the low 8/16/32/64 bits replicated across all lanes.
REQ-028 A load SHALL extract i_mem_rdata >> (8*addr[2:0]) at the request size and extend it to 64 bits: B/H/W sign-extend, BU/HU/WU/D zero-extend.
REQ-029 The load result SHALL be captured in the ack cycle.
REQ-030 A store SHALL drive o_load_data=0.
REQ-031 A new request SHALL NOT be accepted before the DONE->IDLE transition; the maximum rate is one request per 3 cycles.

Reset
REQ-032 While i_rst is high, the state SHALL go to IDLE and o_mem_req, o_mem_we, o_done, o_misaligned, o_illegal SHALL be 0.
REQ-033 While i_rst is high, o_mem_be SHALL be 0x00 and o_mem_addr, o_mem_wdata and o_load_data SHALL be 0.
REQ-034 A reset in REQ SHALL abandon the access with no o_done; a late ack SHALL be ignored.
REQ-035 o_req_ready SHALL be 1 in the first cycle after i_rst deasserts.

Structure
REQ-036 Package lsu_pkg SHALL hold the funct3 size enum, the FSM state enum and the byte-enable base constants.
REQ-037 Load extraction and extension SHALL live in the combinational sub-module lsu_load_align.
REQ-038 Store lane placement and fault detection SHALL stay in load_store_unit.

Verification
REQ-039 LW addr 0x1004, rdata 0x87654321_00000000 -> o_load_data 0xFFFFFFFF_87654321; the same with LWU -> 0x00000000_87654321.
REQ-040 SB addr 0x2003, data 0xAB -> mem_addr 0x2000, be 0x08, wdata 0xABABABAB_ABABABAB, we=1.
REQ-041 LH addr 0x1001 -> no o_mem_req, o_done at T+1 with o_misaligned=1, o_load_data=0; a load with funct3=111 -> o_illegal=1.
REQ-042 LD with the ack delayed 3 cycles -> o_mem_req high 4 cycles with stable addr, o_req_ready=0, a second i_req_valid is ignored, o_done at T+5.
REQ-043 LD with the ack in the first REQ cycle -> o_done at T+2.
REQ-044 i_rst pulsed in REQ, then a stray ack -> no o_done, o_mem_req=0, o_req_ready=1 on the next cycle.
